alu_iter: RTL and testbench

Parametrised successor to the single-cycle integer ALU: a `WIDTH`-bit execution unit with a valid/ready handshake on both sides. Logic, add/sub, shift and compare ops complete in one registered cycle. Multiply and unsigned divide/remainder run iteratively, one bit per cycle. It sits in the pipeline's execute stage and stalls upstream through `in_ready` while an iterative op is in flight.

---
 rtl/alu_iter.sv | 152 +++++++++++++++
 tb/tb_alu_iter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - WIDTH-bit ALU with single-cycle ops and iterative multiply/divide
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] arg1,
    input  logic [WIDTH-1:0] arg2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    state_t               state;
    state_t               state_nx;
    logic [SHW:0]         cnt;
    logic                 sel_div;
    logic                 sel_hi;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic [WIDTH-1:0]     alu_res;
    logic [SHW-1:0]       sh;
    logic                 accept;
    logic                 iter_op;
    logic                 is_mul;
    logic                 last_step;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready && !flush;
    assign iter_op   = (op >= 4'd10) && (op <= 4'd13);
    assign is_mul    = (op[3:1] == 3'b101);
    assign last_step = (state == S_BUSY) && (cnt == CNT_ONE);
    assign sh        = arg2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            4'd0:    alu_res = arg1 + arg2;
            4'd1:    alu_res = arg1 - arg2;
            4'd2:    alu_res = arg1 ^ arg2;
            4'd3:    alu_res = arg1 | arg2;
            4'd4:    alu_res = arg1 & arg2;
            4'd5:    alu_res = arg1 << sh;
            4'd6:    alu_res = arg1 >> sh;
            4'd7:    alu_res = $unsigned($signed(arg1) >>> sh);
            4'd8:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(arg1) < $signed(arg2))};
            4'd9:    alu_res = {{(WIDTH-1){1'b0}}, (arg1 < arg2)};
            default: alu_res = '0;
        endcase
    end

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    // Divide: acc = {partial remainder, dividend bits becoming quotient}, shifted left.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd};
        if (!rem_diff[WIDTH])
            div_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        acc_step = sel_div ? div_next : mul_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept)
                        state_nx = iter_op ? S_BUSY : S_DONE;
                end
                S_BUSY: begin
                    if (cnt == CNT_ONE)
                        state_nx = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        if (accept)
                            state_nx = iter_op ? S_BUSY : S_DONE;
                        else
                            state_nx = S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // A divide by zero needs no special case: every step subtracts zero, so the
    // quotient fills with ones and the dividend shifts through into the remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sel_div <= 1'b0;
            sel_hi  <= 1'b0;
            opnd    <= '0;
            acc     <= '0;
            out     <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            sel_div <= op[2];
            sel_hi  <= op[0];
            if (iter_op) begin
                cnt  <= CNT_INIT;
                opnd <= is_mul ? arg1 : arg2;
                acc  <= {{WIDTH{1'b0}}, (is_mul ? arg2 : arg1)};
            end else begin
                cnt <= '0;
                out <= alu_res;
            end
        end else if (state == S_BUSY) begin
            acc <= acc_step;
            cnt <= cnt - CNT_ONE;
            if (last_step)
                out <= sel_hi ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - randomized self-checking bench for alu_iter
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] arg1;
    logic [31:0] arg2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .arg1      (arg1),
        .arg2      (arg2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa;
        int                 s;
        s  = int'(b[4:0]);
        sa = a;
        p  = {32'd0, a} * {32'd0, b};
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a << s;
            4'd6:    return a >> s;
            4'd7:    return sa >>> s;
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return p[31:0];
            4'd11:   return p[63:32];
            4'd12:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13:   return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Issues one op from idle and waits for its result; lat counts cycles from acceptance.
    task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int rdy_bad);
        @(negedge clk);
        op = f; arg1 = a; arg2 = b; in_valid = 1'b1; out_ready = 1'b1;
        rdy_bad = in_ready ? 0 : 1000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        res = 32'hDEAD_BEEF;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                res = out;
                lat = i;
                break;
            end
            if (in_ready) rdy_bad++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; arg1 = '0; arg2 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out !== 32'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b out=%h ready=%b required 0/00000000/1", out_valid, out, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: valid=%b ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b1; op = 4'd0; arg1 = 32'hFFFF_FFFF; arg2 = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out !== 32'h0000_0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_add: valid=%b out=%h ready=%b required 1/00000000/1", out_valid, out, in_ready);
        end
        op = 4'd1; arg1 = 32'd0; arg2 = 32'd1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out !== 32'hFFFF_FFFF || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sub: valid=%b out=%h ready=%b required 1/ffffffff/1", out_valid, out, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] res;
        logic [31:0] exp_prev;
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          rb;
        int          r;
        logic [3:0]  dops [3]  = '{4'd7, 4'd8, 4'd9};
        logic [31:0] dexp [3]  = '{32'hF800_0000, 32'd1, 32'd0};
        logic [31:0] da   [3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] db   [3]  = '{32'h0000_0024, 32'd1, 32'd1};
        for (int i = 0; i < 3; i++) begin
            run_op(dops[i], da[i], db[i], res, lat, rb);
            checks++;
            if (res !== dexp[i] || lat != 1 || rb != 0) begin
                errors++;
                $display("FAIL single_op%0d: out=%h lat=%0d ready_err=%0d required %h/1/0", dops[i], res, lat, rb, dexp[i]);
            end
        end
        // Streaming random single-cycle ops with out_ready held high.
        exp_prev = '0;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out !== exp_prev || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_%0d: valid=%b out=%h ready=%b required 1/%h/1", i, out_valid, out, in_ready, exp_prev);
                end
            end
            if (i < 40) begin
                r = int'($urandom_range(0, 11));
                f = (r < 10) ? 4'(r) : 4'(r + 4);
                a = $urandom;
                b = $urandom;
                if (r % 3 == 0) b = a;
                op = f; arg1 = a; arg2 = b; in_valid = 1'b1;
                exp_prev = ref_alu(f, a, b);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_iter_directed();
        logic [31:0] res;
        int          lat;
        int          rb;
        logic [3:0]  dops [6] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd12, 4'd13};
        logic [31:0] da   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd5, 32'd5};
        logic [31:0] db   [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0};
        logic [31:0] dexp [6] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
        for (int i = 0; i < 6; i++) begin
            run_op(dops[i], da[i], db[i], res, lat, rb);
            checks++;
            if (res !== dexp[i] || lat != 33 || rb != 0) begin
                errors++;
                $display("FAIL iter_op%0d_%0d: out=%h lat=%0d ready_err=%0d required %h/33/0", dops[i], i, res, lat, rb, dexp[i]);
            end
        end
    endtask

    task automatic test_iter_random();
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        logic [3:0]  f;
        int          lat;
        int          rb;
        for (int i = 0; i < 12; i++) begin
            f = 4'(10 + $urandom_range(0, 3));
            a = $urandom;
            case (i % 4)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            e = ref_alu(f, a, b);
            run_op(f, a, b, res, lat, rb);
            checks++;
            if (res !== e || lat != 33 || rb != 0) begin
                errors++;
                $display("FAIL iter_rand_%0d op%0d a=%h b=%h: out=%h lat=%0d ready_err=%0d required %h/33/0", i, f, a, b, res, lat, rb, e);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_x;
        int          bad;
        @(negedge clk);
        op = 4'd0; arg1 = 32'd1; arg2 = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 op = 4'd2; arg1 = 32'hFFFF_0000; arg2 = 32'h0F0F_0F0F;
        exp_x = ref_alu(4'd2, 32'hFFFF_0000, 32'h0F0F_0F0F);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out !== 32'd3 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: bad_cycles=%0d required 0", bad);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out !== exp_x) begin
            errors++;
            $display("FAIL stall_next_op: valid=%b out=%h required 1/%h", out_valid, out, exp_x);
        end
    endtask

    task automatic test_flush_reset();
        logic [31:0] res;
        int          lat;
        int          rb;
        int          seen;
        @(negedge clk);
        out_ready = 1'b1; op = 4'd12; arg1 = 32'd100; arg2 = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: valid=%b ready=%b required 0/1", out_valid, in_ready);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_result: valid_cycles=%0d required 0", seen);
        end
        op = 4'd10; arg1 = 32'h1234_5678; arg2 = 32'h9ABC_DEF0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 32'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mul: valid=%b out=%h ready=%b required 0/00000000/1", out_valid, out, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || out !== 32'd0) begin
            errors++;
            $display("FAIL reset_no_result: valid_cycles=%0d out=%h required 0/00000000", seen, out);
        end
        run_op(4'd0, 32'd2, 32'd3, res, lat, rb);
        checks++;
        if (res !== 32'd5 || lat != 1 || rb != 0) begin
            errors++;
            $display("FAIL post_reset_add: out=%h lat=%0d ready_err=%0d required 00000005/1/0", res, lat, rb);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_iter_directed();
        test_iter_random();
        test_stall();
        test_flush_reset();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
